// File: rtl/fft_stage_sequencer_if.sv
// Butterfly-unit handshake between the FFT stage sequencer (master) and the
// butterfly datapath (slave): operand addresses, twiddle index and retire pulse.
interface fft_stage_sequencer_if #(
    parameter int LOG2N = 4
);
    logic             bf_valid;
    logic             bf_ready;
    logic             bf_done;
    logic [LOG2N-1:0] bf_addr_a;
    logic [LOG2N-1:0] bf_addr_b;
    logic [LOG2N-2:0] bf_twiddle;

    modport master (
        output bf_valid,
        output bf_addr_a,
        output bf_addr_b,
        output bf_twiddle,
        input  bf_ready,
        input  bf_done
    );

    modport slave (
        input  bf_valid,
        input  bf_addr_a,
        input  bf_addr_b,
        input  bf_twiddle,
        output bf_ready,
        output bf_done
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 in-place FFT stage sequencer: issues N/2 butterflies per stage, waits
// for all write-backs before advancing, and flags unmatched completions.
module fft_stage_sequencer #(
    parameter int LOG2N = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    fft_stage_sequencer_if.master bf,
    output logic                  stage_strobe,
    output logic [3:0]            stage_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        DRAIN   = 2'd2,
        ADVANCE = 2'd3
    } state_e;

    localparam logic [3:0]       LAST_S = 4'(LOG2N - 1);
    localparam logic [LOG2N-2:0] K_LAST = '1;
    localparam logic [LOG2N-1:0] ONE    = {{(LOG2N-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [LOG2N-2:0] k_q;
    logic [3:0]       s_q;
    logic [LOG2N-1:0] outstanding_q;
    logic [LOG2N-1:0] outstanding_d;
    logic             err_q;
    logic             err_d;

    logic             issue_s;
    logic             transfer_s;
    logic             start_acc_s;
    logic             stray_s;
    logic [LOG2N-1:0] k_ext_s;
    logic [LOG2N-1:0] pos_s;
    logic [LOG2N-1:0] addr_a_s;
    logic [LOG2N-1:0] addr_b_s;
    logic [LOG2N-2:0] tw_s;

    assign issue_s     = (state_q == ISSUE);
    assign transfer_s  = issue_s & bf.bf_ready;
    assign start_acc_s = (state_q == IDLE) & start;

    // Butterfly k of stage s: insert a zero at bit s of k to get the upper leg.
    always_comb begin
        k_ext_s  = {1'b0, k_q};
        pos_s    = k_ext_s & ((ONE << s_q) - ONE);
        addr_a_s = ((k_ext_s >> s_q) << (s_q + 4'd1)) | pos_s;
        addr_b_s = addr_a_s | (ONE << s_q);
        tw_s     = pos_s[LOG2N-2:0] << (LAST_S - s_q);
    end

    // Outstanding-operation bookkeeping and sticky error on unmatched completions.
    always_comb begin
        outstanding_d = outstanding_q;
        stray_s       = 1'b0;
        case ({transfer_s, bf.bf_done})
            2'b10: outstanding_d = outstanding_q + ONE;
            2'b01: begin
                if (outstanding_q != '0) begin
                    outstanding_d = outstanding_q - ONE;
                end else begin
                    stray_s = 1'b1;
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
        if (start_acc_s) begin
            err_d = 1'b0;
        end else if (stray_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Sequencer FSM: butterfly index, stage index and outstanding counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            s_q           <= 4'd0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ISSUE;
                        k_q     <= '0;
                        s_q     <= 4'd0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    if (transfer_s) begin
                        if (k_q == K_LAST) begin
                            k_q     <= '0;
                            state_q <= DRAIN;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end else begin
                        k_q <= k_q;
                    end
                end
                // Next-state count lets the final write-back retire the stage one cycle later.
                DRAIN: begin
                    if (outstanding_d == '0) begin
                        state_q <= ADVANCE;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                ADVANCE: begin
                    if (s_q == LAST_S) begin
                        s_q     <= 4'd0;
                        state_q <= IDLE;
                    end else begin
                        s_q     <= s_q + 4'd1;
                        state_q <= ISSUE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    k_q     <= '0;
                    s_q     <= 4'd0;
                end
            endcase
        end
    end

    assign bf.bf_valid   = issue_s;
    assign bf.bf_addr_a  = issue_s ? addr_a_s : '0;
    assign bf.bf_addr_b  = issue_s ? addr_b_s : '0;
    assign bf.bf_twiddle = issue_s ? tw_s : '0;
    assign stage_strobe  = (state_q == ADVANCE);
    assign done          = (state_q == ADVANCE) & (s_q == LAST_S);
    assign busy          = (state_q != IDLE);
    assign stage_count   = busy ? s_q : 4'd0;
    assign err           = err_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer at N=8: expected butterflies are queued
// at start and popped on every issue transfer; hand-written corner sequences follow.
module tb_fft_stage_sequencer;
    logic       clk;
    logic       reset;
    logic       start;
    logic       stage_strobe;
    logic [3:0] stage_count;
    logic       busy;
    logic       done;
    logic       err;

    fft_stage_sequencer_if #(.LOG2N(3)) bif ();

    fft_stage_sequencer #(.LOG2N(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bf           (bif),
        .stage_strobe (stage_strobe),
        .stage_count  (stage_count),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
        logic [3:0] stg;
    } op_t;

    op_t  tbl [12];
    op_t  sb_q [$];
    int   errors;
    int   checks;
    int   issue_cnt;
    int   strobe_cnt;
    int   done_cnt;
    int   stall_cnt;
    logic [1:0] rdy_mode;
    logic rdy_v;
    logic man_ready;
    logic man_done;
    logic resp_en;
    logic [1:0] pipe;
    logic prev_stall;
    logic [2:0] st_a;
    logic [2:0] st_b;
    logic [1:0] st_tw;
    logic exp_valid;
    logic exp_strobe;
    int   out_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_all();
        for (int i = 0; i < 12; i++) sb_q.push_back(tbl[i]);
    endtask

    // One clock: drive ready/done at the falling edge, monitor, return 1 after the rising edge.
    task automatic step();
        logic xfer;
        logic dv;
        logic in_drain;
        op_t  e;
        @(negedge clk);
        case (rdy_mode)
            2'd0:    rdy_v = 1'b1;
            2'd1:    rdy_v = ~rdy_v;
            default: rdy_v = man_ready;
        endcase
        bif.bf_ready = rdy_v;
        xfer = bif.bf_valid & rdy_v;
        dv   = (resp_en & pipe[1]) | man_done;
        pipe = {pipe[0], xfer};
        bif.bf_done = dv;
        if (reset) begin
            prev_stall = 1'b0;
            exp_valid  = 1'b0;
            out_m      = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {bif.bf_valid, bif.bf_addr_a, bif.bf_addr_b, bif.bf_twiddle},
                    {1'b1, st_a, st_b, st_tw});
                stall_cnt++;
            end
            if (exp_valid) chk("drain_exit", stage_strobe, exp_strobe);
            if (stage_strobe) begin
                chk("strobe_no_valid", bif.bf_valid, 1'b0);
                chk("strobe_stage", stage_count, strobe_cnt % 3);
                strobe_cnt++;
            end
            if (done) begin
                chk("done_last", {stage_strobe, stage_count}, {1'b1, 4'd2});
                done_cnt++;
            end
            if (xfer) begin
                issue_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: actual=%0h/%0h required=nothing",
                             bif.bf_addr_a, bif.bf_addr_b);
                end else begin
                    e = sb_q.pop_front();
                    chk("issue_op", {bif.bf_addr_a, bif.bf_addr_b, bif.bf_twiddle, stage_count}, e);
                end
            end
            prev_stall = bif.bf_valid & ~rdy_v;
            st_a  = bif.bf_addr_a;
            st_b  = bif.bf_addr_b;
            st_tw = bif.bf_twiddle;
            in_drain = busy & ~bif.bf_valid & ~stage_strobe;
            if (xfer & ~dv) out_m++;
            else if (~xfer & dv & (out_m > 0)) out_m--;
            exp_valid  = in_drain;
            exp_strobe = (out_m == 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == base) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: actual=no done in %0d cycles required=done", budget);
        end
    endtask

    task automatic check_run(input string tag, input int i0, input int s0, input int d0);
        chk({tag, "_issues"}, issue_cnt - i0, 12);
        chk({tag, "_strobes"}, strobe_cnt - s0, 3);
        chk({tag, "_dones"}, done_cnt - d0, 1);
        chk({tag, "_sb_left"}, sb_q.size(), 0);
        step();
        chk({tag, "_idle"}, {busy, stage_count, bif.bf_valid}, 6'd0);
    endtask

    initial begin
        int i0;
        int s0;
        int d0;
        int n;
        tbl[0]  = '{3'd0, 3'd1, 2'd0, 4'd0};
        tbl[1]  = '{3'd2, 3'd3, 2'd0, 4'd0};
        tbl[2]  = '{3'd4, 3'd5, 2'd0, 4'd0};
        tbl[3]  = '{3'd6, 3'd7, 2'd0, 4'd0};
        tbl[4]  = '{3'd0, 3'd2, 2'd0, 4'd1};
        tbl[5]  = '{3'd1, 3'd3, 2'd2, 4'd1};
        tbl[6]  = '{3'd4, 3'd6, 2'd0, 4'd1};
        tbl[7]  = '{3'd5, 3'd7, 2'd2, 4'd1};
        tbl[8]  = '{3'd0, 3'd4, 2'd0, 4'd2};
        tbl[9]  = '{3'd1, 3'd5, 2'd1, 4'd2};
        tbl[10] = '{3'd2, 3'd6, 2'd2, 4'd2};
        tbl[11] = '{3'd3, 3'd7, 2'd3, 4'd2};
        errors = 0; checks = 0; issue_cnt = 0; strobe_cnt = 0; done_cnt = 0; stall_cnt = 0;
        rdy_mode = 2'd0; rdy_v = 1'b0; man_ready = 1'b0; man_done = 1'b0; resp_en = 1'b0;
        pipe = 2'b00; prev_stall = 1'b0; exp_valid = 1'b0; exp_strobe = 1'b0; out_m = 0;
        st_a = 3'd0; st_b = 3'd0; st_tw = 2'd0;
        bif.bf_ready = 1'b0;
        bif.bf_done  = 1'b0;
        reset = 1'b1;
        start = 1'b0;

        // Reset state.
        for (int i = 0; i < 3; i++) step();
        chk("rst_outs", {bif.bf_valid, bif.bf_addr_a, bif.bf_addr_b, bif.bf_twiddle,
                         stage_strobe, stage_count, busy, done, err}, 21'd0);
        reset = 1'b0;
        step();

        // Full transform, always ready, completion two cycles after each issue.
        resp_en = 1'b1;
        push_all();
        i0 = issue_cnt; s0 = strobe_cnt; d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_valid", {bif.bf_valid, busy, stage_count}, {1'b1, 1'b1, 4'd0});
        run_until_done(200);
        chk("a_err", err, 1'b0);
        check_run("a", i0, s0, d0);

        // Stray completion in IDLE sets sticky err; accepted start clears it.
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        chk("stray_err", err, 1'b1);
        step();
        chk("stray_sticky", err, 1'b1);

        // Ready toggling every cycle, with start re-pulsed while busy.
        rdy_mode = 2'd1;
        push_all();
        i0 = issue_cnt; s0 = strobe_cnt; d0 = done_cnt; n = stall_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_clears_err", err, 1'b0);
        for (int i = 0; i < 5; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(400);
        chk("b_stalls_seen", (stall_cnt - n) > 0, 1'b1);
        check_run("b", i0, s0, d0);

        // Write-backs withheld after stage 0: sequencer must sit in DRAIN.
        rdy_mode = 2'd0;
        resp_en  = 1'b0;
        push_all();
        i0 = issue_cnt; s0 = strobe_cnt; d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (issue_cnt - i0 < 4 && n < 20) begin
            step();
            n++;
        end
        chk("c_stage0_issued", issue_cnt - i0, 4);
        for (int i = 0; i < 10; i++) begin
            chk("c_drain_hold", {bif.bf_valid, busy, stage_strobe}, 3'b010);
            step();
        end
        man_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("c_no_early_strobe", stage_strobe, 1'b0);
            step();
        end
        man_done = 1'b0;
        resp_en  = 1'b1;
        chk("c_strobe_after_last", {stage_strobe, stage_count}, {1'b1, 4'd0});
        run_until_done(200);
        check_run("c", i0, s0, d0);

        // Reset mid-ISSUE with err set, then start on the first edge after release.
        rdy_mode  = 2'd2;
        man_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("d_issue_k0", {bif.bf_valid, bif.bf_addr_a, bif.bf_addr_b}, {1'b1, 3'd0, 3'd1});
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        chk("d_err_in_issue", err, 1'b1);
        step();
        #2 reset = 1'b1;
        #1;
        chk("d_async_reset", {bif.bf_valid, bif.bf_addr_a, bif.bf_addr_b, bif.bf_twiddle,
                              stage_strobe, stage_count, busy, done, err}, 21'd0);
        step();
        step();
        reset    = 1'b0;
        rdy_mode = 2'd0;
        push_all();
        i0 = issue_cnt; s0 = strobe_cnt; d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("d_start_after_reset", {bif.bf_valid, busy}, 2'b11);
        run_until_done(200);
        check_run("d", i0, s0, d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
